// File: rtl/rv32i_pkg.sv
// Shared package: default payload width and the skid buffer occupancy states.
package rv32i_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/skid_word_reg.sv
// One storage word of the skid buffer: enable-gated register, async active-high reset to 0.
module skid_word_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_skid_buffer.sv
// Two-entry registered skid buffer: main word feeds m_data, skid word catches the word
// accepted in the cycle downstream stalls, so both handshake outputs come straight from flops.
module reg_skid_buffer
    import rv32i_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    skid_state_e      r_state;
    skid_state_e      w_state_d;
    logic             r_s_ready;
    logic             r_m_valid;
    logic             w_main_en;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    always_comb begin
        w_state_d = r_state;
        w_main_en = 1'b0;
        w_skid_en = 1'b0;
        w_main_d  = s_data;
        unique case (r_state)
            StEmpty: begin
                if (s_valid) begin
                    w_main_en = 1'b1;
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                if (s_valid) begin
                    if (m_ready) begin
                        w_main_en = 1'b1;
                    end else begin
                        // Downstream stalled: park the new word, keep main stable.
                        w_skid_en = 1'b1;
                        w_state_d = StFull;
                    end
                end else if (m_ready) begin
                    w_state_d = StEmpty;
                end
            end
            StFull: begin
                if (m_ready) begin
                    w_main_en = 1'b1;
                    w_main_d  = w_skid_q;
                    w_state_d = StBusy;
                end
            end
            default: begin
                w_state_d = StEmpty;
            end
        endcase
    end

    // Handshake outputs are registered from the next state, never decoded from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StEmpty;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_s_ready <= (w_state_d != StFull);
            r_m_valid <= (w_state_d != StEmpty);
        end
    end

    skid_word_reg #(
        .WIDTH (WIDTH)
    ) u_main (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_main_en),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    skid_word_reg #(
        .WIDTH (WIDTH)
    ) u_skid (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_skid_en),
        .i_d   (s_data),
        .o_q   (w_skid_q)
    );

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = w_main_q;

endmodule

// File: tb/tb_reg_skid_buffer.sv
// Directed and scoreboarded random stimulus for reg_skid_buffer.
module tb_reg_skid_buffer;

    localparam int unsigned WIDTH = 32;
    localparam int          NUM_RAND_WORDS = 10000;
    localparam int          RAND_CYCLE_LIMIT = 80000;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    int n_vec;
    int n_err;

    reg_skid_buffer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and checks happen 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic exp_mv, input logic [31:0] exp_md,
                             input logic exp_sr);
        check({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, exp_mv});
        if (exp_mv) check({tag, ".m_data"}, m_data, exp_md);
        check({tag, ".s_ready"}, {31'd0, s_ready}, {31'd0, exp_sr});
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] next_word;
        logic [31:0] prev_data;
        logic        prev_hold;
        logic        exp_sr;
        logic        exp_mv;
        int          sent;
        int          recvd;
        int          cycles;

        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        m_ready = 1'b0;

        // Reset state, with inputs active to show they are ignored.
        #2;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        m_ready = 1'b1;
        tick();
        check_out("reset", 1'b0, 32'h0, 1'b1);
        check("reset.m_data", m_data, 32'h0);
        s_valid = 1'b0;
        rst     = 1'b0;
        tick();
        check_out("post_reset_idle", 1'b0, 32'h0, 1'b1);

        // Pass-through: eight words back to back with m_ready held high.
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            tick();
            check_out($sformatf("pass%0d", i), 1'b1, 32'(i), 1'b1);
        end
        s_valid = 1'b0;
        tick();
        check_out("pass_end", 1'b0, 32'h0, 1'b1);

        // Back-pressure, then drain from FULL with s_valid low.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hAAAA_0001;
        tick();
        check_out("bp_first", 1'b1, 32'hAAAA_0001, 1'b1);
        s_data = 32'hAAAA_0002;
        tick();
        check_out("bp_full", 1'b1, 32'hAAAA_0001, 1'b0);
        s_data = 32'hBBBB_0000;
        tick();
        check_out("bp_hold", 1'b1, 32'hAAAA_0001, 1'b0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        check_out("drain1", 1'b1, 32'hAAAA_0002, 1'b1);
        tick();
        check_out("drain2", 1'b0, 32'h0, 1'b1);

        // Simultaneous accept and deliver in BUSY: s_ready must never drop.
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = 32'hC000_0000 + 32'(i);
            tick();
            check_out($sformatf("simul%0d", i), 1'b1, 32'hC000_0000 + 32'(i), 1'b1);
        end
        s_valid = 1'b0;
        tick();

        // Async reset while FULL discards both words before any edge.
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h5555_0001;
        tick();
        s_data = 32'h5555_0002;
        tick();
        check_out("pre_rst_full", 1'b1, 32'h5555_0001, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 32'h0, 1'b1);
        check("async_rst.m_data", m_data, 32'h0);
        tick();
        rst     = 1'b0;
        m_ready = 1'b1;
        s_data  = 32'h1234_5678;
        tick();
        check_out("after_rst_first", 1'b1, 32'h1234_5678, 1'b1);
        s_valid = 1'b0;
        tick();
        check_out("after_rst_empty", 1'b0, 32'h0, 1'b1);

        // Random handshakes against a queue model.
        next_word = 32'h0001_0000;
        sent      = 0;
        recvd     = 0;
        cycles    = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        while (recvd < NUM_RAND_WORDS && cycles < RAND_CYCLE_LIMIT) begin
            exp_sr = (exp_q.size() < 2);
            exp_mv = (exp_q.size() > 0);
            check("rand.s_ready", {31'd0, s_ready}, {31'd0, exp_sr});
            check("rand.m_valid", {31'd0, m_valid}, {31'd0, exp_mv});
            if (prev_hold) check("rand.stable", m_data, prev_data);
            s_valid = (sent < NUM_RAND_WORDS) ? 1'($urandom_range(1)) : 1'b0;
            m_ready = 1'($urandom_range(1));
            s_data  = s_valid ? next_word : 32'($urandom);
            prev_hold = exp_mv && !m_ready;
            prev_data = m_data;
            if (exp_mv && m_ready) begin
                check("rand.order", m_data, exp_q.pop_front());
                recvd++;
            end
            if (s_valid && exp_sr) begin
                exp_q.push_back(next_word);
                next_word++;
                sent++;
            end
            tick();
            cycles++;
        end
        check("rand.words_received", 32'(recvd), 32'(NUM_RAND_WORDS));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_skid_buffer.md
REG_SKID_BUFFER -- requirements
Module: reg_skid_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning payload width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a reset that is asynchronous and active-high.
REQ-004 The block SHALL have port s_data, input, WIDTH, the upstream payload.
REQ-005 The block SHALL have port s_valid, input, 1, meaning upstream offers s_data.
REQ-006 The block SHALL have port s_ready, output, 1, meaning the block accepts s_data this cycle.
REQ-007 The block SHALL have port m_data, output, WIDTH, the downstream payload.
REQ-008 The block SHALL have port m_valid, output, 1, meaning m_data holds a valid word.
REQ-009 The block SHALL have port m_ready, input, 1, meaning downstream consumes m_data this cycle.

Function
REQ-010 The block SHALL transfer a word upstream when s_valid and s_ready are both 1 at a rising clk edge, and downstream when m_valid and m_ready are both 1.
REQ-011 The block SHALL hold a main register and a skid register (2 words total), with states EMPTY (0 words), BUSY (main only) and FULL (main and skid).
REQ-012 The block SHALL drive outputs from flops only: s_ready = (state != FULL), m_valid = (state != EMPTY), m_data = main register.
REQ-013 From EMPTY, when s_valid=1, the block SHALL load main and go to BUSY; otherwise it SHALL stay in EMPTY.
REQ-014 From BUSY, when s_valid=1 and m_ready=1, the block SHALL load main with s_data and stay in BUSY.
REQ-015 From BUSY, when s_valid=1 and m_ready=0, the block SHALL load skid with s_data and go to FULL, leaving main unchanged.
REQ-016 From BUSY, when s_valid=0 and m_ready=1, the block SHALL go to EMPTY; when s_valid=0 and m_ready=0, it SHALL hold.
REQ-017 From FULL, when m_ready=1, the block SHALL copy skid to main and go to BUSY; s_data is ignored because s_ready=0.
REQ-018 Latency SHALL be 1 cycle: a word accepted at edge N is on m_data with m_valid=1 after edge N.
REQ-019 Sustained throughput SHALL be 1 word per cycle while m_ready=1.
REQ-020 While m_valid=1 and m_ready=0, m_data SHALL remain stable, and words SHALL never be dropped, duplicated or reordered.
REQ-021 In EMPTY the block SHALL ignore m_ready, and it SHALL ignore s_data whenever s_valid=0.
REQ-022 The block SHALL contain no combinational path from m_ready to s_ready or from s_valid to m_valid.

Reset
REQ-023 While rst=1, state SHALL be EMPTY, main and skid SHALL be 0, and outputs SHALL be m_valid=0, m_data=0, s_ready=1.
REQ-024 Inputs SHALL be ignored while rst=1.
REQ-025 Assertion of rst in any state, including FULL, SHALL discard all held words immediately, without waiting for a clk edge.
REQ-026 After rst is deasserted, the first rising clk edge SHALL behave as EMPTY.

Structure
REQ-027 The state enum (EMPTY, BUSY, FULL) SHALL be a typedef in the shared CPU package rv32i_pkg, alongside the default data width constant.
REQ-028 Each WIDTH-bit storage word SHALL be one instance of a sub-module skid_word_reg: an enable-gated register with async active-high reset to 0.

Verification
REQ-029 Reset: hold rst=1 mid-stream with state FULL -> m_valid=0, s_ready=1 and m_data=0 immediately; the next word sent after release comes out first.
REQ-030 Pass-through: with m_ready=1, send 0x00000001..0x00000008 on consecutive cycles -> the same 8 words appear in order, one cycle later each, with m_valid=1 for 8 consecutive cycles.
REQ-031 Back-pressure: send 0xAAAA0001 then 0xAAAA0002 with m_ready=0 -> s_ready=0 after the second accept; m_data=0xAAAA0001 stays stable; raising m_ready delivers 0xAAAA0001 then 0xAAAA0002.
REQ-032 Simultaneous events: in BUSY with s_valid=1 and m_ready=1 every cycle -> state stays BUSY and s_ready never drops.
REQ-033 Random: randomise s_valid and m_ready at 50% each over 10000 words -> the scoreboard shows zero loss, duplication or reordering, and no cycle with m_data changing while m_valid=1 and m_ready=0.
REQ-034 Drain: in FULL, assert m_ready=1 for 2 cycles with s_valid=0 -> m_valid=1, m_valid=1, then 0, ending in EMPTY.
